// File: rtl/cam_pkg.sv
// Shared definitions for the synthetic camera source: FSM states, pattern codes
// and the RGB565 colour-bar palette.
package cam_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_VSYNC  = 3'd1,
      ST_VBP    = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_VFP    = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      PAT_BARS    = 2'd0,
      PAT_RAMP    = 2'd1,
      PAT_SOLID   = 2'd2,
      PAT_CHECKER = 2'd3
   } pattern_t;

   localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
   localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
   localparam logic [15:0] BAR_CYAN    = 16'h07FF;
   localparam logic [15:0] BAR_GREEN   = 16'h07E0;
   localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
   localparam logic [15:0] BAR_RED     = 16'hF800;
   localparam logic [15:0] BAR_BLUE    = 16'h001F;
   localparam logic [15:0] BAR_BLACK   = 16'h0000;

   function automatic logic [15:0] bar_color(input logic [2:0] idx);
      case (idx)
         3'd0:    return BAR_WHITE;
         3'd1:    return BAR_YELLOW;
         3'd2:    return BAR_CYAN;
         3'd3:    return BAR_GREEN;
         3'd4:    return BAR_MAGENTA;
         3'd5:    return BAR_RED;
         3'd6:    return BAR_BLUE;
         default: return BAR_BLACK;
      endcase
   endfunction

   function automatic int max_of4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/cam_pattern_gen.sv
// Combinational RGB565 pixel generator for the synthetic camera patterns.
module cam_pattern_gen
   import cam_pkg::*;
#(
   parameter int H_ACTIVE = 640
) (
   input  logic [15:0] x,
   input  logic        y_tile,
   input  pattern_t    pattern,
   input  logic [15:0] color,
   input  logic        frame_lsb,
   output logic [15:0] pixel
);

   localparam logic [15:0] BAR_W = 16'(H_ACTIVE / 8);

   logic [2:0] bar_idx;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      bar_idx = 3'(x / BAR_W);
      pixel   = 16'h0000;
      case (pattern)
         PAT_BARS:    pixel = bar_color(bar_idx);
         PAT_RAMP:    pixel = {x[7:3], x[7:2], x[7:3]};
         PAT_SOLID:   pixel = color;
         PAT_CHECKER: pixel = (x[4] ^ y_tile ^ frame_lsb) ? 16'hFFFF : 16'h0000;
         default:     pixel = 16'h0000;
      endcase
   end

endmodule

// File: rtl/cam_pattern_tx.sv
// OV7670-style vsync/href/byte source with VGA-like timing and frame-latched test patterns.
// FSM, horizontal/line counters and one output register stage.
module cam_pattern_tx
   import cam_pkg::*;
#(
   parameter int H_ACTIVE    = 640,
   parameter int H_BLANK     = 288,
   parameter int V_ACTIVE    = 480,
   parameter int VSYNC_LINES = 3,
   parameter int VBP_LINES   = 17,
   parameter int VFP_LINES   = 10
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_en,
   input  logic [1:0]  i_pattern,
   input  logic [15:0] i_color,
   output logic        o_vsync,
   output logic        o_href,
   output logic [7:0]  o_data,
   output logic        o_busy,
   output logic        o_frame_done,
   output logic [7:0]  o_frame_cnt
);

   localparam int H_TOTAL   = 2 * H_ACTIVE + H_BLANK;
   localparam int HW        = $clog2(H_TOTAL);
   localparam int MAX_LINES = max_of4(V_ACTIVE, VSYNC_LINES, VBP_LINES, VFP_LINES);
   localparam int LW        = $clog2(MAX_LINES + 1);
   // Selects bit 4 of the line index; collapses to zero when the line counter is narrower.
   localparam logic [LW-1:0] Y_TILE_MASK = LW'(16);

   state_t         state, state_nxt;
   logic [HW-1:0]  h_cnt, h_cnt_nxt;
   logic [LW-1:0]  line_cnt, line_cnt_nxt;
   logic [LW-1:0]  state_lines;
   pattern_t       pattern_q;
   logic [15:0]    color_q;
   logic           line_end, state_end, frame_end, latch;
   logic           href_nxt;
   logic [15:0]    pixel;
   logic [7:0]     byte_nxt;

   always_comb begin
      case (state)
         ST_VSYNC:  state_lines = LW'(VSYNC_LINES);
         ST_VBP:    state_lines = LW'(VBP_LINES);
         ST_ACTIVE: state_lines = LW'(V_ACTIVE);
         ST_VFP:    state_lines = LW'(VFP_LINES);
         default:   state_lines = LW'(1);
      endcase
      line_end  = (h_cnt == HW'(H_TOTAL - 1));
      state_end = line_end && (line_cnt == state_lines - 1'b1);
      frame_end = (state == ST_VFP) && state_end;
   end

   always_comb begin
      state_nxt    = state;
      h_cnt_nxt    = h_cnt;
      line_cnt_nxt = line_cnt;
      latch        = 1'b0;
      if (state == ST_IDLE) begin
         h_cnt_nxt    = '0;
         line_cnt_nxt = '0;
         if (i_en) begin
            state_nxt = ST_VSYNC;
            latch     = 1'b1;
         end
      end else begin
         h_cnt_nxt = line_end ? '0 : h_cnt + 1'b1;
         if (line_end) line_cnt_nxt = state_end ? '0 : line_cnt + 1'b1;
         if (state_end) begin
            case (state)
               ST_VSYNC:  state_nxt = ST_VBP;
               ST_VBP:    state_nxt = ST_ACTIVE;
               ST_ACTIVE: state_nxt = ST_VFP;
               ST_VFP: begin
                  // Back-to-back frames relatch the pattern inputs with no idle gap.
                  if (i_en) begin
                     state_nxt = ST_VSYNC;
                     latch     = 1'b1;
                  end else begin
                     state_nxt = ST_IDLE;
                  end
               end
               default:   state_nxt = ST_IDLE;
            endcase
         end
      end
   end

   cam_pattern_gen #(
      .H_ACTIVE (H_ACTIVE)
   ) u_gen (
      .x         (16'(h_cnt >> 1)),
      .y_tile    (|(line_cnt & Y_TILE_MASK)),
      .pattern   (pattern_q),
      .color     (color_q),
      .frame_lsb (o_frame_cnt[0]),
      .pixel     (pixel)
   );

   always_comb begin
      href_nxt = (state == ST_ACTIVE) && (h_cnt < HW'(2 * H_ACTIVE));
      byte_nxt = 8'h00;
      if (href_nxt) byte_nxt = h_cnt[0] ? pixel[7:0] : pixel[15:8];
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state     <= ST_IDLE;
         h_cnt     <= '0;
         line_cnt  <= '0;
         pattern_q <= PAT_BARS;
         color_q   <= 16'h0000;
      end else begin
         state    <= state_nxt;
         h_cnt    <= h_cnt_nxt;
         line_cnt <= line_cnt_nxt;
         if (latch) begin
            pattern_q <= pattern_t'(i_pattern);
            color_q   <= i_color;
         end
      end
   end

   // Output stage: every output is registered from the same state/counter snapshot.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         o_vsync      <= 1'b0;
         o_href       <= 1'b0;
         o_data       <= 8'h00;
         o_busy       <= 1'b0;
         o_frame_done <= 1'b0;
         o_frame_cnt  <= 8'h00;
      end else begin
         o_vsync      <= (state == ST_VSYNC);
         o_href       <= href_nxt;
         o_data       <= byte_nxt;
         o_busy       <= (state != ST_IDLE);
         o_frame_done <= frame_end;
         if (frame_end) o_frame_cnt <= o_frame_cnt + 8'd1;
      end
   end

endmodule
